// File: rtl/top_proc_pkg.sv
// Shared types for the multicycle RV32I-subset core: FSM states, opcodes,
// ALU operations and the decoded-control bundle latched at the end of ID.
package top_proc_pkg;

  localparam logic [31:0] INITIAL_PC_DEF = 32'h0040_0000;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_op_t;

  // Everything the later states need to know about the instruction
  typedef struct packed {
    alu_op_t    op;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic [4:0] rd;
  } ctrl_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/rv_alu.sv
// 32-bit ALU for the multicycle core; Zero flag drives the BEQ decision.
module rv_alu
  import top_proc_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     op_i,
  output logic [31:0] y_o,
  output logic        zero_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLT: y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLL: y_o = a_i << b_i[4:0];
      ALU_SRL: y_o = a_i >> b_i[4:0];
      ALU_SRA: y_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == 32'd0);

endmodule

// File: rtl/top_proc_mc.sv
// Multicycle RV32I-subset core, IF->ID->EX->MEM->WB, one instruction per 5 cycles.
// Define SHIFT_IMM_EN to execute SLLI/SRLI/SRAI; otherwise they decode as NOPs.
module top_proc_mc
  import top_proc_pkg::*;
#(
  parameter logic [31:0] INITIAL_PC = INITIAL_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [31:0] PC,
  output logic [31:0] dAddress,
  output logic [31:0] dWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] WriteBackData,
  input  logic [31:0] dReadData
);

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] rf_q [32];
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] a_q, b_q, rs2_q, immb_q, alu_q;
  logic        zero_q;

  logic        id_en, ex_en, rf_we, pc_we;
  logic [31:0] alu_y;
  logic        alu_zero;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:    state_d = S_ID;
      S_ID:    state_d = S_EX;
      S_EX:    state_d = S_MEM;
      S_MEM:   state_d = S_WB;
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    id_en    = (state_q == S_ID);
    ex_en    = (state_q == S_EX);
    MemRead  = (state_q == S_MEM) && ctrl_q.mem_rd;
    MemWrite = (state_q == S_MEM) && ctrl_q.mem_wr;
    rf_we    = (state_q == S_WB) && ctrl_q.reg_we && (ctrl_q.rd != 5'd0);
    pc_we    = (state_q == S_WB);
  end

  // ---------------- Decode (valid in ID) ----------------
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, op2;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rs1_v  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_v  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign imm_i  = sext12(instr[31:20]);
  assign imm_s  = sext12({instr[31:25], instr[11:7]});
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    ctrl_d    = '0;
    ctrl_d.op = ALU_ADD;
    ctrl_d.rd = instr[11:7];
    op2       = rs2_v;
    case (opcode)
      OP_R: begin
        ctrl_d.reg_we = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: ctrl_d.op = ALU_ADD;
          10'b0100000_000: ctrl_d.op = ALU_SUB;
          10'b0000000_001: ctrl_d.op = ALU_SLL;
          10'b0000000_010: ctrl_d.op = ALU_SLT;
          10'b0000000_100: ctrl_d.op = ALU_XOR;
          10'b0000000_101: ctrl_d.op = ALU_SRL;
          10'b0100000_101: ctrl_d.op = ALU_SRA;
          10'b0000000_110: ctrl_d.op = ALU_OR;
          10'b0000000_111: ctrl_d.op = ALU_AND;
          default:         ctrl_d.reg_we = 1'b0;
        endcase
      end
      OP_IMM: begin
        ctrl_d.reg_we = 1'b1;
        op2           = imm_i;  // shamt sits in imm_i[4:0]
        case (funct3)
          3'b000:  ctrl_d.op = ALU_ADD;
          3'b010:  ctrl_d.op = ALU_SLT;
          3'b100:  ctrl_d.op = ALU_XOR;
          3'b110:  ctrl_d.op = ALU_OR;
          3'b111:  ctrl_d.op = ALU_AND;
`ifdef SHIFT_IMM_EN
          3'b001: begin
            if (funct7 == 7'b0000000) ctrl_d.op = ALU_SLL;
            else                      ctrl_d.reg_we = 1'b0;
          end
          3'b101: begin
            if (funct7 == 7'b0000000)      ctrl_d.op = ALU_SRL;
            else if (funct7 == 7'b0100000) ctrl_d.op = ALU_SRA;
            else                           ctrl_d.reg_we = 1'b0;
          end
`endif
          default: ctrl_d.reg_we = 1'b0;
        endcase
      end
      OP_LOAD: begin
        op2 = imm_i;
        if (funct3 == 3'b010) begin
          ctrl_d.reg_we = 1'b1;
          ctrl_d.mem_rd = 1'b1;
        end
      end
      OP_STORE: begin
        op2 = imm_s;
        if (funct3 == 3'b010) ctrl_d.mem_wr = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_d.op = ALU_SUB;
        if (funct3 == 3'b000) ctrl_d.branch = 1'b1;
      end
      default: ;
    endcase
  end

  rv_alu u_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .op_i   (ctrl_q.op),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= INITIAL_PC;
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rs2_q  <= '0;
      immb_q <= '0;
      alu_q  <= '0;
      zero_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (id_en) begin
        ctrl_q <= ctrl_d;
        a_q    <= rs1_v;
        b_q    <= op2;
        rs2_q  <= rs2_v;
        immb_q <= imm_b;
      end
      if (ex_en) begin
        alu_q  <= alu_y;
        zero_q <= alu_zero;
      end
      if (rf_we) rf_q[ctrl_q.rd] <= WriteBackData;
      if (pc_we) pc_q <= (ctrl_q.branch && zero_q) ? pc_q + immb_q : pc_q + 32'd4;
    end
  end

  assign PC            = pc_q;
  assign dAddress      = alu_q;
  assign dWriteData    = rs2_q;
  assign WriteBackData = ctrl_q.mem_rd ? dReadData : alu_q;

endmodule

// File: tb/tb_top_proc_mc.sv
// Bench for top_proc_mc: directed programs plus random instruction streams
// checked cycle by cycle against an instruction-level model.
module tb_top_proc_mc;

  localparam logic [31:0] INIT = 32'h0040_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] dReadData = '0;
  logic [31:0] PC, dAddress, dWriteData, WriteBackData;
  logic        MemRead, MemWrite;

  always #5 clk = ~clk;

  top_proc_mc #(.INITIAL_PC(INIT)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .PC            (PC),
    .dAddress      (dAddress),
    .dWriteData    (dWriteData),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .WriteBackData (WriteBackData),
    .dReadData     (dReadData)
  );

  // Environment: instruction ROM (lazily filled) and 64-word data RAM
  logic [31:0] rom [logic [31:0]];
  bit          rand_mode = 1'b0;
  logic [31:0] ram [64];

  // Reference model state
  logic [31:0] mregs [32];
  logic [31:0] mmem  [64];
  logic [31:0] mpc;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (model pc %h)", tag, got, exp, mpc);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [11:0] imm;
    int          off;
    rd  = 5'($urandom_range(0, 15));
    r1  = 5'($urandom_range(0, 15));
    r2  = 5'($urandom_range(0, 15));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 9: return enc_i(imm, r1, f3, rd, 7'b0010011);
      2, 3:    return enc_r(($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000, f3, rd, r1, r2);
      4:       return {($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000, r2, r1,
                       ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b001, rd, 7'b0010011};
      5:       return enc_s(12'($urandom_range(0, 63) * 4), r2, 5'd0);
      6:       return enc_i(12'($urandom_range(0, 63) * 4), 5'd0, 3'b010, rd, 7'b0000011);
      7: begin
        off = ($urandom_range(0, 6) - 2) * 4;
        if (off == 0) off = 8;
        return enc_b(13'(off), r2, r1, 3'b000);
      end
      default: begin
        case ($urandom_range(0, 2))
          0:       return {imm, r1, f3, rd, 7'b0110111};
          1:       return enc_i(imm, r1, 3'b000, rd, 7'b0000011);
          default: return enc_b(13'd8, r2, r1, 3'b001);
        endcase
      end
    endcase
  endfunction

  function automatic logic [31:0] fetch(input logic [31:0] a);
    if (!rom.exists(a)) rom[a] = rand_mode ? rand_instr() : NOP;
    return rom[a];
  endfunction

  always @(posedge clk) instr <= fetch(PC);

  always @(posedge clk) begin
    if (MemWrite) ram[dAddress[7:2]] <= dWriteData;
    dReadData <= ram[dAddress[7:2]];
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mpc = INIT;
  endtask

  // Execute one instruction in the model and check the DUT across its 5 cycles
  task automatic run_instr();
    logic [31:0] ir, rs1v, rs2v, immi, imms, immb, res, nxt, addr;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          wr, mr, mw;
    ir   = fetch(mpc);
    opc  = ir[6:0];
    f3   = ir[14:12];
    f7   = ir[31:25];
    rd   = ir[11:7];
    rs1v = mregs[ir[19:15]];
    rs2v = mregs[ir[24:20]];
    immi = {{20{ir[31]}}, ir[31:20]};
    imms = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    immb = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    nxt  = mpc + 32'd4;
    res  = '0;
    addr = '0;
    wr = 0; mr = 0; mw = 0;
    case (opc)
      7'b0110011: begin
        wr = 1;
        if (f7 == 7'h00 && f3 == 3'd0)      res = rs1v + rs2v;
        else if (f7 == 7'h20 && f3 == 3'd0) res = rs1v - rs2v;
        else if (f7 == 7'h00 && f3 == 3'd7) res = rs1v & rs2v;
        else if (f7 == 7'h00 && f3 == 3'd6) res = rs1v | rs2v;
        else if (f7 == 7'h00 && f3 == 3'd4) res = rs1v ^ rs2v;
        else if (f7 == 7'h00 && f3 == 3'd2) res = ($signed(rs1v) < $signed(rs2v)) ? 32'd1 : 32'd0;
        else if (f7 == 7'h00 && f3 == 3'd1) res = rs1v << rs2v[4:0];
        else if (f7 == 7'h00 && f3 == 3'd5) res = rs1v >> rs2v[4:0];
        else if (f7 == 7'h20 && f3 == 3'd5) res = 32'($signed(rs1v) >>> rs2v[4:0]);
        else wr = 0;
      end
      7'b0010011: begin
        wr = 1;
        if (f3 == 3'd0)      res = rs1v + immi;
        else if (f3 == 3'd7) res = rs1v & immi;
        else if (f3 == 3'd6) res = rs1v | immi;
        else if (f3 == 3'd4) res = rs1v ^ immi;
        else if (f3 == 3'd2) res = ($signed(rs1v) < $signed(immi)) ? 32'd1 : 32'd0;
`ifdef SHIFT_IMM_EN
        else if (f3 == 3'd1 && f7 == 7'h00) res = rs1v << ir[24:20];
        else if (f3 == 3'd5 && f7 == 7'h00) res = rs1v >> ir[24:20];
        else if (f3 == 3'd5 && f7 == 7'h20) res = 32'($signed(rs1v) >>> ir[24:20]);
`endif
        else wr = 0;
      end
      7'b0000011: if (f3 == 3'd2) begin
        wr = 1; mr = 1;
        addr = rs1v + immi;
        res  = mmem[addr[7:2]];
      end
      7'b0100011: if (f3 == 3'd2) begin
        mw = 1;
        addr = rs1v + imms;
      end
      7'b1100011: if (f3 == 3'd0 && rs1v == rs2v) nxt = mpc + immb;
      default: ;
    endcase

    @(negedge clk);  // IF
    chk("pc", PC, mpc);
    chk("memctl_if", {30'b0, MemRead, MemWrite}, 32'd0);
    @(negedge clk);  // ID
    chk("memctl_id", {30'b0, MemRead, MemWrite}, 32'd0);
    @(negedge clk);  // EX
    chk("memctl_ex", {30'b0, MemRead, MemWrite}, 32'd0);
    @(negedge clk);  // MEM
    chk("memctl_mem", {30'b0, MemRead, MemWrite}, {30'b0, mr, mw});
    if (mr || mw) chk("daddr", dAddress, addr);
    if (mw) chk("wdata", dWriteData, rs2v);
    @(negedge clk);  // WB
    chk("memctl_wb", {30'b0, MemRead, MemWrite}, 32'd0);
    if (wr && rd != 5'd0) chk("wbdata", WriteBackData, res);

    if (wr && rd != 5'd0) mregs[rd] = res;
    if (mw) mmem[addr[7:2]] = rs2v;
    mpc = nxt;
  endtask

  task automatic load_prog(input logic [31:0] p [$]);
    rom.delete();
    foreach (p[i]) rom[INIT + 32'(i) * 4] = p[i];
  endtask

  initial begin
    logic [31:0] prog [$];
    for (int i = 0; i < 64; i++) begin
      ram[i]  = '0;
      mmem[i] = '0;
    end

    // Arithmetic plus a taken backward branch at INIT+0x10
    prog = '{enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011),
             enc_i(12'd7, 5'd0, 3'd0, 5'd2, 7'b0010011),
             enc_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2),
             enc_r(7'h20, 3'd0, 5'd4, 5'd1, 5'd2),
             enc_b(13'(-8), 5'd1, 5'd1, 3'd0)};
    load_prog(prog);
    do_reset();
    for (int i = 0; i < 8; i++) run_instr();

    // SLT/SRA, store/load, untaken branch, x0 handling, unsupported encodings
    prog = '{enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011),
             enc_i(12'd7, 5'd0, 3'd0, 5'd2, 7'b0010011),
             enc_r(7'h20, 3'd0, 5'd4, 5'd1, 5'd2),
             enc_r(7'h00, 3'd2, 5'd5, 5'd4, 5'd1),
             enc_r(7'h20, 3'd5, 5'd6, 5'd4, 5'd1),
             enc_s(12'd8, 5'd2, 5'd0),
             enc_i(12'd8, 5'd0, 3'd2, 5'd7, 7'b0000011),
             enc_b(13'd8, 5'd2, 5'd1, 3'd0),
             enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'b0010011),
             enc_r(7'h00, 3'd0, 5'd8, 5'd0, 5'd0),
             {7'h20, 5'd1, 5'd4, 3'b101, 5'd9, 7'b0010011},
             {7'h00, 5'd3, 5'd1, 3'b001, 5'd10, 7'b0010011},
             enc_r(7'h00, 3'd3, 5'd11, 5'd4, 5'd1),
             enc_i(12'hFFF, 5'd4, 3'd2, 5'd12, 7'b0010011),
             enc_i(12'h800, 5'd1, 3'd0, 5'd13, 7'b0010011)};
    load_prog(prog);
    do_reset();
    for (int i = 0; i < 15; i++) run_instr();

    // Reset landing in EX of an ADDI: restart at INIT without the write
    prog = '{enc_i(12'd3, 5'd0, 3'd0, 5'd9, 7'b0010011)};
    load_prog(prog);
    do_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mpc = INIT;
    rom[INIT] = enc_r(7'h00, 3'd0, 5'd10, 5'd9, 5'd0);
    run_instr();
    run_instr();

    // Random instruction streams
    rand_mode = 1'b1;
    for (int s = 0; s < 4; s++) begin
      rom.delete();
      do_reset();
      for (int i = 0; i < 120; i++) run_instr();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
